// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing block: opcode encodings, FSM states
// and default widths.
package alu_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_OP_W   = 3;
  localparam int DEFAULT_CNT_W  = 16;

  localparam logic [2:0] OP_OR   = 3'b000;
  localparam logic [2:0] OP_AND  = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_NOR  = 3'b100;
  localparam logic [2:0] OP_NAND = 3'b101;
  localparam logic [2:0] OP_SLT  = 3'b110;
  localparam logic [2:0] OP_SUB  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way round-robin grant with its priority flop; prio points at the
// requester that wins the next tie and moves to the loser on each grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

  logic prio_reg;

  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = prio_reg ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_reg <= 1'b0;
    end else if (advance) begin
      prio_reg <= grant[0];
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU between two requesters, one
// transaction in flight: accept -> drive ALU -> hold response until taken.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int OP_W   = DEFAULT_OP_W,
  parameter int CNT_W  = DEFAULT_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_result,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_result,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] a_reg, b_reg, result_reg;
  logic [OP_W-1:0]   op_reg;
  logic              owner_reg;
  logic [CNT_W-1:0]  op_count_reg;

  logic [1:0] valid_idle;
  logic [1:0] grant;
  logic       accept;
  logic       rsp_fire;

  // Ready is combinational from valid, so it is also held low while reset is up.
  assign valid_idle = (state_reg == IDLE && !rst) ? {req1_valid, req0_valid} : 2'b00;
  assign accept     = |grant;
  assign rsp_fire   = (state_reg == RESP) && (owner_reg ? rsp1_ready : rsp0_ready);

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .valid   (valid_idle),
    .advance (accept),
    .grant   (grant)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_fire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg        <= '0;
      b_reg        <= '0;
      op_reg       <= '0;
      owner_reg    <= 1'b0;
      result_reg   <= '0;
      op_count_reg <= '0;
    end else begin
      if (accept) begin
        a_reg     <= grant[1] ? req1_a  : req0_a;
        b_reg     <= grant[1] ? req1_b  : req0_b;
        op_reg    <= grant[1] ? req1_op : req0_op;
        owner_reg <= grant[1];
      end
      if (state_reg == EXEC) begin
        result_reg <= alu_result;
      end
      if (rsp_fire) begin
        op_count_reg <= op_count_reg + 1'b1;
      end
    end
  end

  assign req0_ready  = grant[0];
  assign req1_ready  = grant[1];
  assign alu_a       = (state_reg == EXEC) ? a_reg  : '0;
  assign alu_b       = (state_reg == EXEC) ? b_reg  : '0;
  assign alu_op      = (state_reg == EXEC) ? op_reg : '0;
  assign rsp0_valid  = (state_reg == RESP) && !owner_reg;
  assign rsp1_valid  = (state_reg == RESP) &&  owner_reg;
  assign rsp0_result = result_reg;
  assign rsp1_result = result_reg;
  assign busy        = (state_reg != IDLE);
  assign op_count    = op_count_reg;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomised and directed checks of alu_share_arbiter against a transaction
// level model (grant order, ALU result, completion count).
module tb_alu_share_arbiter;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_op, req1_op;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [2:0]  alu_op;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp0_result, rsp1_result;
  logic        busy;
  logic [3:0]  op_count;

  int total = 0;
  int bad   = 0;
  int prio_m  = 0;
  int count_m = 0;
  int txn_n   = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.DATA_W(32), .OP_W(3), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
    .busy(busy), .op_count(op_count)
  );

  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] op);
    case (op)
      OP_OR:   return a | b;
      OP_AND:  return a & b;
      OP_XOR:  return a ^ b;
      OP_ADD:  return a + b;
      OP_NOR:  return ~(a | b);
      OP_NAND: return ~(a & b);
      OP_SLT:  return (a < b) ? 32'h1 : 32'h0;
      default: return a - b;
    endcase
  endfunction

  // External ALU attached to the block
  assign alu_result = alu_fn(alu_a, alu_b, alu_op);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_busy"}, 32'(busy), 32'h0);
    check_eq({tag, "_rsp0v"}, 32'(rsp0_valid), 32'h0);
    check_eq({tag, "_rsp1v"}, 32'(rsp1_valid), 32'h0);
    check_eq({tag, "_alu_a"}, alu_a, 32'h0);
    check_eq({tag, "_alu_b"}, alu_b, 32'h0);
    check_eq({tag, "_alu_op"}, 32'(alu_op), 32'h0);
  endtask

  // Call at posedge+1 with the block idle. Leaves the non-grantee valid.
  task automatic run_txn(input bit v0, input bit v1,
                         input logic [31:0] a0, input logic [31:0] b0, input logic [2:0] op0,
                         input logic [31:0] a1, input logic [31:0] b1, input logic [2:0] op1,
                         input int hold);
    int g;
    logic [31:0] ea, eb, er;
    logic [2:0] eo;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
    g  = (v0 && v1) ? prio_m : (v0 ? 0 : 1);
    ea = g ? a1 : a0;
    eb = g ? b1 : b0;
    eo = g ? op1 : op0;
    er = alu_fn(ea, eb, eo);
    #1;
    check_eq("req0_ready", 32'(req0_ready), 32'(g == 0));
    check_eq("req1_ready", 32'(req1_ready), 32'(g == 1));
    check_idle_outputs("idle");
    @(posedge clk); #1;
    prio_m = 1 - g;
    // Grantee withdraws and scrambles its operands; the latched copy must win.
    if (g == 0) begin
      req0_valid = 1'b0; req0_a = $urandom; req0_b = $urandom; req0_op = 3'($urandom_range(0, 7));
    end else begin
      req1_valid = 1'b0; req1_a = $urandom; req1_b = $urandom; req1_op = 3'($urandom_range(0, 7));
    end
    #1;
    check_eq("exec_busy", 32'(busy), 32'h1);
    check_eq("exec_req0_ready", 32'(req0_ready), 32'h0);
    check_eq("exec_req1_ready", 32'(req1_ready), 32'h0);
    check_eq("exec_alu_a", alu_a, ea);
    check_eq("exec_alu_b", alu_b, eb);
    check_eq("exec_alu_op", 32'(alu_op), 32'(eo));
    check_eq("exec_rsp_valid", 32'({rsp1_valid, rsp0_valid}), 32'h0);
    @(posedge clk); #1;
    check_eq("resp_rsp0_valid", 32'(rsp0_valid), 32'(g == 0));
    check_eq("resp_rsp1_valid", 32'(rsp1_valid), 32'(g == 1));
    check_eq("resp_result", g ? rsp1_result : rsp0_result, er);
    check_eq("resp_alu_a", alu_a, 32'h0);
    check_eq("resp_alu_op", 32'(alu_op), 32'h0);
    if (g == 0) rsp1_ready = 1'($urandom_range(0, 1));
    else        rsp0_ready = 1'($urandom_range(0, 1));
    repeat (hold) begin
      @(posedge clk); #1;
      check_eq("hold_rsp_valid", 32'({rsp1_valid, rsp0_valid}), g ? 32'h2 : 32'h1);
      check_eq("hold_result", g ? rsp1_result : rsp0_result, er);
      check_eq("hold_req_ready", 32'({req1_ready, req0_ready}), 32'h0);
      check_eq("hold_busy", 32'(busy), 32'h1);
    end
    if (g == 0) rsp0_ready = 1'b1;
    else        rsp1_ready = 1'b1;
    @(posedge clk); #1;
    count_m = (count_m + 1) % 16;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    check_eq("done_op_count", 32'(op_count), 32'(count_m));
    check_eq("done_busy", 32'(busy), 32'h0);
    check_eq("done_rsp_valid", 32'({rsp1_valid, rsp0_valid}), 32'h0);
    txn_n++;
    $display("txn %0d owner=%0d op=%0d a=%h b=%h result=%h count=%0d",
             txn_n, g, eo, ea, eb, er, op_count);
  endtask

  task automatic run_random(input int hold_max);
    bit v0, v1;
    v0 = 1'($urandom_range(0, 1));
    v1 = 1'($urandom_range(0, 1));
    if (!v0 && !v1) v0 = 1'b1;
    run_txn(v0, v1,
            $urandom, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom,
            3'($urandom_range(0, 7)),
            $urandom, $urandom, 3'($urandom_range(0, 7)),
            $urandom_range(0, hold_max));
  endtask

  // Call at posedge+1 with the block idle; stage 0 = reset in EXEC, 1 = in RESP.
  task automatic reset_mid(input int stage);
    req0_valid = 1'b1; req0_a = 32'h1234; req0_b = 32'h1; req0_op = OP_ADD;
    req1_valid = 1'b0;
    @(posedge clk); #1;
    if (stage == 1) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    check_idle_outputs(stage ? "rst_resp" : "rst_exec");
    check_eq("rst_req0_ready", 32'(req0_ready), 32'h0);
    check_eq("rst_op_count", 32'(op_count), 32'h0);
    check_eq("rst_rsp_result", rsp0_result, 32'h0);
    @(posedge clk); #1;
    check_eq("rst_hold_rsp0v", 32'(rsp0_valid), 32'h0);
    rst = 1'b0;
    req0_valid = 1'b0;
    prio_m  = 0;
    count_m = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    prio_m  = 0;
    count_m = 0;
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 1'b1; req1_a = '0; req1_b = '0; req1_op = '0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    check_eq("reset_req1_ready", 32'(req1_ready), 32'h0);
    check_eq("reset_op_count", 32'(op_count), 32'h0);
    check_eq("reset_rsp0_result", rsp0_result, 32'h0);
    req1_valid = 1'b0;
    rst = 1'b0;

    run_txn(1, 0, 32'd5, 32'd3, OP_ADD, 32'h0, 32'h0, OP_OR, 0);

    do_reset();
    run_txn(1, 1, 32'd10, 32'd4, OP_SUB, 32'hFFFF0000, 32'h0000FFFF, OP_XOR, 1);
    run_txn(0, 1, 32'h0, 32'h0, OP_OR, 32'hFFFF0000, 32'h0000FFFF, OP_XOR, 0);
    run_txn(1, 1, $urandom, $urandom, OP_AND, $urandom, $urandom, OP_OR, 0);

    // prio now favours req1; req0 stays pending through the backpressure
    run_txn(1, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, OP_NAND, 32'd1, 32'd2, OP_SLT, 5);
    run_txn(1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, OP_NAND, 32'h0, 32'h0, OP_OR, 0);

    reset_mid(0);
    reset_mid(1);
    run_txn(0, 1, 32'd7, 32'd9, OP_SLT, 32'd7, 32'd9, OP_SLT, 0);

    do_reset();
    run_txn(1, 0, 32'hFFFFFFFF, 32'h1, OP_ADD, 32'h0, 32'h0, OP_OR, 0);
    for (int i = 0; i < 16; i++) run_random(2);
    check_eq("wrap_op_count", 32'(op_count), 32'h1);

    for (int i = 0; i < 40; i++) run_random(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
